// File: rtl/pam4_lock_packer.sv
// PAM4 CDR lock judge and Gray-coded symbol packer: 4 symbols per byte, emitted only while locked.
// Optional PRBS7 byte checker is built when PAM4_PRBS_CHK_EN is defined.
module pam4_lock_packer #(
    parameter int PHI_TOL    = 64,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_en,
    input  logic [3:0]  sym,
    input  logic [15:0] phi,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        locked,
    output logic [1:0]  state,
    output logic [7:0]  sym_err_cnt,
    output logic [7:0]  prbs_err_cnt
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t              st;
    logic [RUN_W-1:0]    run;
    logic [MISS_W-1:0]   miss;
    logic [1:0]          slot;
    logic [5:0]          sh;
    logic [15:0]         phi_prev;
    logic                phi_prev_valid;

    logic                legal;
    logic [1:0]          code;
    logic [16:0]         d;
    logic [16:0]         d_abs;
    logic                good;
    logic                lock_enter;
    logic                lock_lose;
    logic                emit;
    logic [7:0]          packed_byte;

    always_comb begin
        legal = 1'b1;
        code  = 2'b00;
        case (sym)
            4'hD:    code = 2'b00;
            4'hF:    code = 2'b01;
            4'h1:    code = 2'b11;
            4'h3:    code = 2'b10;
            default: legal = 1'b0;
        endcase
    end

    // Sign-extend to 17 bits so the difference of any two 16-bit phases cannot overflow.
    assign d     = {phi[15], phi} - {phi_prev[15], phi_prev};
    assign d_abs = d[16] ? (~d + 17'd1) : d;
    assign good  = legal && phi_prev_valid && (d_abs <= 17'(PHI_TOL));

    assign lock_enter  = sample_en && (st == VERIFY) && good && (run == RUN_W'(LOCK_CNT - 1));
    assign lock_lose   = sample_en && (st == LOCKED) && !good && (miss == MISS_W'(UNLOCK_CNT - 1));
    assign emit        = sample_en && (st == LOCKED) && !lock_lose && (slot == 2'd3);
    assign packed_byte = {sh, code};
    assign state       = st;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st             <= SEARCH;
            run            <= '0;
            miss           <= '0;
            slot           <= 2'd0;
            sh             <= 6'd0;
            phi_prev       <= 16'd0;
            phi_prev_valid <= 1'b0;
            byte_out       <= 8'd0;
            byte_valid     <= 1'b0;
            locked         <= 1'b0;
            sym_err_cnt    <= 8'd0;
        end else begin
            byte_valid <= emit;
            if (emit)
                byte_out <= packed_byte;
            if (sample_en) begin
                phi_prev       <= phi;
                phi_prev_valid <= 1'b1;
                if (!legal && sym_err_cnt != 8'hFF)
                    sym_err_cnt <= sym_err_cnt + 8'd1;
                unique case (st)
                    SEARCH: begin
                        if (good) begin
                            st  <= VERIFY;
                            run <= RUN_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (lock_enter) begin
                            st     <= LOCKED;
                            locked <= 1'b1;
                            run    <= '0;
                            miss   <= '0;
                            slot   <= 2'd0;
                        end else if (good) begin
                            run <= run + 1'b1;
                        end else begin
                            st  <= SEARCH;
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (lock_lose) begin
                            st     <= SEARCH;
                            locked <= 1'b0;
                            miss   <= '0;
                            slot   <= 2'd0;
                        end else begin
                            miss <= good ? '0 : miss + 1'b1;
                            slot <= slot + 1'b1;
                            sh   <= {sh[3:0], code};
                        end
                    end
                    default: begin
                        st     <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PAM4_PRBS_CHK_EN
    // hist[0] is the newest received bit, hist[6] the one seven bits back.
    logic [6:0] hist;
    logic [6:0] hist_nxt;
    logic [2:0] seed;
    logic [2:0] seed_nxt;
    logic [3:0] mism;
    logic [8:0] perr_sum;

    always_comb begin
        hist_nxt = hist;
        seed_nxt = seed;
        mism     = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (seed_nxt == 3'd7)
                mism = mism + {3'b000, hist_nxt[6] ^ hist_nxt[5] ^ packed_byte[i]};
            else
                seed_nxt = seed_nxt + 3'd1;
            hist_nxt = {hist_nxt[5:0], packed_byte[i]};
        end
    end

    assign perr_sum = {1'b0, prbs_err_cnt} + {5'd0, mism};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist         <= 7'd0;
            seed         <= 3'd0;
            prbs_err_cnt <= 8'd0;
        end else if (lock_enter) begin
            seed <= 3'd0;
        end else if (emit) begin
            hist         <= hist_nxt;
            seed         <= seed_nxt;
            prbs_err_cnt <= perr_sum[8] ? 8'hFF : perr_sum[7:0];
        end
    end
`else
    assign prbs_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pam4_lock_packer.sv
// Randomized and directed bench for pam4_lock_packer against a sample-level behavioural model.
module tb_pam4_lock_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic [3:0]  sym = 4'd0;
    logic [15:0] phi = 16'd0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        locked;
    logic [1:0]  state;
    logic [7:0]  sym_err_cnt;
    logic [7:0]  prbs_err_cnt;

    pam4_lock_packer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .sym          (sym),
        .phi          (phi),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .locked       (locked),
        .state        (state),
        .sym_err_cnt  (sym_err_cnt),
        .prbs_err_cnt (prbs_err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state (0 SEARCH, 1 VERIFY, 2 LOCKED)
    int m_state, m_run, m_miss, m_prev, m_serr, m_perr, m_byte;
    bit m_pv, m_bv;
    int m_codes[$];
    bit m_bits[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int gray(input int v);
        case (v)
            -3: return 0;
            -1: return 1;
            1:  return 3;
            3:  return 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] code2sym(input int c);
        case (c)
            0: return 4'hD;
            1: return 4'hF;
            3: return 4'h1;
            default: return 4'h3;
        endcase
    endfunction

    task automatic model_prbs(input int b);
        int mism = 0;
        for (int i = 7; i >= 0; i--) begin
            bit bit_i = bit'((b >> i) & 1);
            if (m_bits.size() >= 7) begin
                if ((m_bits[m_bits.size()-7] ^ m_bits[m_bits.size()-6]) != bit_i)
                    mism++;
            end
            m_bits.push_back(bit_i);
            if (m_bits.size() > 7)
                void'(m_bits.pop_front());
        end
        m_perr = (m_perr + mism > 255) ? 255 : m_perr + mism;
    endtask

    task automatic model_step(input bit r, input bit en, input logic [3:0] s, input logic [15:0] p);
        int sv, pv, dd, c;
        bit legal, good;
        m_bv = 1'b0;
        if (!r) begin
            m_state = 0; m_run = 0; m_miss = 0; m_prev = 0; m_serr = 0;
            m_perr = 0; m_byte = 0; m_pv = 1'b0;
            m_codes.delete();
            m_bits.delete();
            return;
        end
        if (!en) return;
        sv = $signed(s);
        pv = $signed(p);
        legal = (sv == -3 || sv == -1 || sv == 1 || sv == 3);
        c = gray(sv);
        if (!legal && m_serr < 255) m_serr++;
        dd = pv - m_prev;
        if (dd < 0) dd = -dd;
        good = legal && m_pv && (dd <= 64);
        m_prev = pv;
        m_pv = 1'b1;
        if (m_state == 0) begin
            if (good) begin m_state = 1; m_run = 1; end
        end else if (m_state == 1) begin
            if (good) begin
                m_run++;
                if (m_run == 16) begin
                    m_state = 2; m_run = 0; m_miss = 0;
                    m_codes.delete();
                    m_bits.delete();
                end
            end else begin
                m_state = 0; m_run = 0;
            end
        end else begin
            m_miss = good ? 0 : m_miss + 1;
            if (m_miss == 4) begin
                m_state = 0; m_miss = 0;
                m_codes.delete();
            end else begin
                m_codes.push_back(c);
                if (m_codes.size() == 4) begin
                    m_byte = (m_codes[0] << 6) | (m_codes[1] << 4) | (m_codes[2] << 2) | m_codes[3];
                    m_bv = 1'b1;
                    m_codes.delete();
`ifdef PAM4_PRBS_CHK_EN
                    model_prbs(m_byte);
`endif
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit en, input logic [3:0] s, input logic [15:0] p);
        rst_n = r; sample_en = en; sym = s; phi = p;
        @(posedge clk);
        model_step(r, en, s, p);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), m_state);
            chk("locked", int'(locked), (m_state == 2) ? 1 : 0);
            chk("byte_valid", int'(byte_valid), int'(m_bv));
            chk("byte_out", int'(byte_out), m_byte);
            chk("sym_err_cnt", int'(sym_err_cnt), m_serr);
`ifdef PAM4_PRBS_CHK_EN
            chk("prbs_err_cnt", int'(prbs_err_cnt), m_perr);
`else
            chk("prbs_err_cnt", int'(prbs_err_cnt), 0);
`endif
        end
    end

    task automatic sample(input logic [3:0] s, input logic [15:0] p);
        cycle(1'b1, 1'b1, s, p);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 4'($urandom), 16'($urandom));
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 4'd0, 16'd0);
        cycle(1'b0, 1'b0, 4'd0, 16'd0);
    endtask

    task automatic acquire_lock();
        for (int i = 1; i <= 17; i++) begin
            sample(4'h1, 16'd100);
            idle();
        end
    endtask

    initial begin
        logic [15:0] cur;
        int bits[$];
        do_reset();
        chk_en = 1'b1;
        chk("reset_state", int'(state), 0);
        chk("reset_outputs", int'({byte_out, byte_valid, locked, sym_err_cnt, prbs_err_cnt}), 0);

        // Lock acquisition timeline
        for (int i = 1; i <= 17; i++) begin
            sample(4'h1, 16'd100);
            if (i == 1)  chk("acq_s1_search", int'(state), 0);
            if (i == 2)  chk("acq_s2_verify", int'(state), 1);
            if (i == 16) chk("acq_s16_verify", int'(state), 1);
            if (i == 17) begin
                chk("acq_s17_locked_state", int'(state), 2);
                chk("acq_s17_locked", int'(locked), 1);
            end
            idle();
        end

        // Packing: -3,-1,+1,+3 -> 00 01 11 10
        sample(4'hD, 16'd100); idle();
        sample(4'hF, 16'd100); idle();
        sample(4'h1, 16'd100); idle();
        sample(4'h3, 16'd100);
        chk("pack_valid", int'(byte_valid), 1);
        chk("pack_byte", int'(byte_out), 8'h1E);
        idle();
        chk("pack_pulse_end", int'(byte_valid), 0);
        chk("pack_byte_hold", int'(byte_out), 8'h1E);

        // Phase steps of exactly 64 keep lock; 4 steps of 65 lose it
        cur = 16'd100;
        for (int i = 0; i < 4; i++) begin cur += 16'd64; sample(4'h1, cur); end
        chk("phase64_locked", int'(state), 2);
        for (int i = 0; i < 4; i++) begin
            cur += 16'd65; sample(4'h1, cur);
            if (i == 2) chk("phase65_3_locked", int'(state), 2);
        end
        chk("phase65_4_search", int'(state), 0);

        // Illegal symbol in VERIFY, then saturation
        do_reset();
        sample(4'h1, 16'd5); sample(4'h1, 16'd5);
        chk("ill_pre_verify", int'(state), 1);
        sample(4'h0, 16'd5);
        chk("ill_search", int'(state), 0);
        chk("ill_cnt1", int'(sym_err_cnt), 1);
        for (int i = 0; i < 300; i++) sample(4'h0, 16'd5);
        chk("ill_sat", int'(sym_err_cnt), 255);

        // Reset with a partial byte pending
        do_reset();
        acquire_lock();
        sample(4'h3, 16'd100); sample(4'h3, 16'd100);
        cycle(1'b0, 1'b0, 4'd0, 16'd0);
        chk("rst_mid_state", int'(state), 0);
        chk("rst_mid_outputs", int'({byte_out, byte_valid, locked, sym_err_cnt}), 0);
        for (int i = 0; i < 6; i++) sample(4'h3, 16'd100);

`ifdef PAM4_PRBS_CHK_EN
        // PRBS7 stream with one flipped bit (index 20)
        do_reset();
        acquire_lock();
        bits = '{1, 0, 1, 1, 0, 0, 1};
        for (int n = 7; n < 40; n++) bits.push_back(bits[n-7] ^ bits[n-6]);
        bits[20] = bits[20] ^ 1;
        for (int k = 0; k < 20; k++) begin
            sample(code2sym(bits[2*k] * 2 + bits[2*k+1]), 16'd100);
            if (k == 7) chk("prbs_clean", int'(prbs_err_cnt), 0);
        end
        chk("prbs_flip3", int'(prbs_err_cnt), 3);
`endif

        // Randomized traffic
        do_reset();
        cur = 16'($urandom);
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] s;
            int pick = $urandom_range(0, 99);
            if (pick < 92) begin
                case ($urandom_range(0, 3))
                    0: s = 4'hD;
                    1: s = 4'hF;
                    2: s = 4'h1;
                    default: s = 4'h3;
                endcase
            end else begin
                s = 4'($urandom_range(0, 15));
            end
            pick = $urandom_range(0, 99);
            if (pick < 85)      cur = cur + 16'($urandom_range(0, 128)) - 16'd64;
            else if (pick < 95) cur = cur + 16'($urandom_range(60, 70));
            else                cur = 16'($urandom);
            if ($urandom_range(0, 999) == 0)
                cycle(1'b0, 1'b0, s, cur);
            else
                cycle(1'b1, $urandom_range(0, 3) != 0, s, cur);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
